mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the MIPS EXE stage. It executes MULT, MULTU, DIV and DIVU by iterating 32 add/subtract steps through a private `alu` instance, then applies sign fix-ups and writes the HI/LO registers. MTHI/MTLO writes go to the same HI/LO registers. The pipeline uses `busy` as a stall source for any MDU-dependent instruction.

---
 rtl/mdu_sequencer_pkg.sv | 33 +++
 rtl/mdu_sequencer_alu.sv | 26 ++
 rtl/mdu_sequencer.sv | 145 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: MDU op encodings,
// the ALU opcodes it borrows, sequencer state encoding and a sign helper.
package mdu_sequencer_pkg;

  localparam int XLEN = 32;

  // op[1] selects divide, op[0] selects unsigned
  localparam logic [1:0] EXE_MDU_MULT  = 2'b00;
  localparam logic [1:0] EXE_MDU_MULTU = 2'b01;
  localparam logic [1:0] EXE_MDU_DIV   = 2'b10;
  localparam logic [1:0] EXE_MDU_DIVU  = 2'b11;

  localparam logic [3:0] EXE_ALU_ADD = 4'd0;
  localparam logic [3:0] EXE_ALU_SUB = 4'd1;
  localparam logic [3:0] EXE_ALU_AND = 4'd2;
  localparam logic [3:0] EXE_ALU_OR  = 4'd3;
  localparam logic [3:0] EXE_ALU_XOR = 4'd4;
  localparam logic [3:0] EXE_ALU_SLT = 4'd5;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // Magnitude of v when treated as signed; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_sequencer_alu.sv
// alu: the EXE-stage integer ALU, reused by the MDU for its add/subtract steps.
// Ports: oper (opcode), sign (signed compare for SLT), a/b operands, result.
module alu
  import mdu_sequencer_pkg::*;
(
  input  logic [3:0]      oper,
  input  logic            sign,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (oper)
      EXE_ALU_ADD: result = a + b;
      EXE_ALU_SUB: result = a - b;
      EXE_ALU_AND: result = a & b;
      EXE_ALU_OR:  result = a | b;
      EXE_ALU_XOR: result = a ^ b;
      EXE_ALU_SLT: result = {31'd0, sign ? ($signed(a) < $signed(b)) : (a < b)};
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: 32-step multiply/divide unit owning HI/LO.
// Ports: clk, rst_n (async low); start/op/rs/rt issue an op; cancel flushes
// it; wr_hi/wr_lo/wdata are MTHI/MTLO; busy stalls the pipe; done pulses when
// HI/LO take a new result; hi/lo are the architectural registers.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic            cancel,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_e state, nxt;
  logic [5:0]      cnt;
  logic            is_div, neg_q, neg_r;
  // mcand: multiplicand (MULT) or divisor (DIV).
  // acc_hi: product high half (MULT) or partial remainder (DIV).
  // acc_lo: multiplier shifting out (MULT) or dividend shifting out / quotient shifting in (DIV).
  logic [XLEN-1:0] mcand, acc_hi, acc_lo;
  logic [3:0]      alu_oper;
  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge, carry, div0, go, sgn;
  logic [63:0]     prod, prod_fix;
  logic [XLEN-1:0] q_fix, r_fix;

  assign busy = (state != MDU_IDLE);
  assign done = (state == MDU_DONE);
  assign sgn  = ~op[0];
  assign div0 = op[1] && (rt == '0);
  assign go   = (state == MDU_IDLE) && start && !cancel;

  // Stored remainder is always < divisor, so 32 bits hold it; the shifted
  // value needs the extra bit and the compare is done at 33 bits.
  assign rem_sh = {acc_hi, acc_lo[XLEN-1]};
  assign rem_ge = rem_sh >= {1'b0, mcand};
  assign carry  = alu_res < acc_hi;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
  assign q_fix    = neg_q ? (~acc_lo + 32'd1) : acc_lo;
  assign r_fix    = neg_r ? (~acc_hi + 32'd1) : acc_hi;

  always_comb begin
    alu_oper = EXE_ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    if (state == MDU_CALC) begin
      alu_oper = is_div ? EXE_ALU_SUB : EXE_ALU_ADD;
      alu_a    = is_div ? rem_sh[XLEN-1:0] : acc_hi;
      alu_b    = mcand;
    end
  end

  alu u_alu (
    .oper   (alu_oper),
    .sign   (1'b0),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MDU_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      MDU_IDLE: if (go) nxt = div0 ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (cancel) nxt = MDU_IDLE;
                else if (cnt == 6'd31) nxt = MDU_FIX;
      MDU_FIX:  nxt = cancel ? MDU_IDLE : MDU_DONE;
      MDU_DONE: nxt = MDU_IDLE;
      default:  nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (!busy) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
      case (state)
        MDU_IDLE: if (go) begin
          if (div0) begin
            // Later assignment: an op issued with MTHI/MTLO overwrites it.
            hi <= rs;
            lo <= '1;
          end else begin
            is_div <= op[1];
            mcand  <= op[1] ? abs32(rt, sgn) : abs32(rs, sgn);
            acc_lo <= op[1] ? abs32(rs, sgn) : abs32(rt, sgn);
            acc_hi <= '0;
            cnt    <= '0;
            neg_q  <= sgn & (rs[XLEN-1] ^ rt[XLEN-1]);
            neg_r  <= sgn & rs[XLEN-1];
          end
        end
        MDU_CALC: begin
          cnt <= cnt + 6'd1;
          if (is_div) begin
            acc_hi <= rem_ge ? alu_res : rem_sh[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], rem_ge};
          end else if (acc_lo[0]) begin
            acc_hi <= {carry, alu_res[XLEN-1:1]};
            acc_lo <= {alu_res[0], acc_lo[XLEN-1:1]};
          end else begin
            acc_hi <= {1'b0, acc_hi[XLEN-1:1]};
            acc_lo <= {acc_hi[0], acc_lo[XLEN-1:1]};
          end
        end
        MDU_FIX: if (!cancel) begin
          hi <= is_div ? r_fix : prod_fix[63:32];
          lo <= is_div ? q_fix : prod_fix[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: expected HI/LO and done cycle are
// queued at issue; a monitor pops and compares on every done pulse.
module tb_mdu_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, cancel = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0, rt = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] hi; logic [31:0] lo; int cyc; } exp_t;
  exp_t sbq[$];
  int cyc = 0, checks = 0, fails = 0;
  logic [31:0] ref_hi = '0, ref_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b00) begin p = sa * sb; return p; end
    if (o == 2'b01) begin p = {32'd0, a} * {32'd0, b}; return p; end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == 2'b10) begin
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Called on a negedge with busy low; start is sampled by the next edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] r;
    r = model(o, a, b);
    op = o; rs = a; rt = b; start = 1'b1;
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.cyc = cyc + ((o[1] && b == 32'd0) ? 1 : 34);
    sbq.push_back(e);
    ref_hi = e.hi;
    ref_lo = e.lo;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          check("result_hilo", {hi, lo}, {e.hi, e.lo});
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin : driver
    int c0;
    logic [1:0]  o;
    logic [31:0] a, b, old_lo;

    #12;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(2'b00, -32'sd3, 32'd7);               wait_idle();
    issue(2'b10, -32'sd7, 32'd2);               wait_idle();
    issue(2'b11, 32'd100, 32'd0);               wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();

    // MTHI while idle
    wr_hi = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk); wr_hi = 1'b0;
    check("mthi_idle", {32'd0, hi}, 64'h1234);
    check("mthi_lo_kept", {32'd0, lo}, {32'd0, ref_lo});
    ref_hi = 32'h1234;

    // MTLO while busy is dropped
    old_lo = lo;
    issue(2'b01, 32'd5, 32'd9);
    wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk); wr_lo = 1'b0;
    check("mtlo_busy", {32'd0, lo}, {32'd0, old_lo});
    wait_idle();

    // cancel beats start while idle
    op = 2'b00; rs = 32'd1; rt = 32'd1; start = 1'b1; cancel = 1'b1;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    check("cancel_beats_start", {63'd0, busy}, 64'd0);

    // MULT 5x6, stray start in cycle 5, cancel in cycle 10
    c0 = cyc;
    op = 2'b00; rs = 32'd5; rt = 32'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < c0 + 5) @(negedge clk);
    rs = 32'd7; rt = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < c0 + 10) @(negedge clk);
    check("busy_before_cancel", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("cancel_idle", {63'd0, busy}, 64'd0);
    check("cancel_hilo_kept", {hi, lo}, {ref_hi, ref_lo});
    repeat (40) @(negedge clk);

    // write and start in the same cycle: write lands, result overwrites later
    wr_hi = 1'b1; wdata = 32'h0000_CAFE;
    issue(2'b01, 32'd3, 32'd4);
    wr_hi = 1'b0;
    check("wr_with_start", {32'd0, hi}, 64'hCAFE);
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 16));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(o, a, b);
      wait_idle();
    end

    // async reset in cycle 20 of a DIVU
    c0 = cyc;
    issue(2'b11, 32'd1000, 32'd7);
    while (cyc < c0 + 20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midop_reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("midop_reset_hilo", {hi, lo}, 64'd0);
    sbq.delete();
    ref_hi = '0; ref_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'd2, 32'd3);
    wait_idle();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
